// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//   Drain side of a show-ahead synchronous FIFO. Words are popped through the
//   FIFO read port into a two-entry buffer (head + skid) and presented to the
//   downstream as a valid/ready stream. o_last frames every BURST_LEN beats.
//
//   The skid entry lets the pop decision depend only on the registered
//   occupancy. There is no combinational path from i_ready to o_fifo_rden.
//   A pop can therefore be in flight while the downstream stalls, and the
//   stream still sustains one word per clock when i_ready stays high.
//
// Parameters
//   DATA_W     width of FIFO read data and stream data
//   BURST_LEN  beats per burst (>= 2); o_last marks beat BURST_LEN-1
//
// Ports
//   clk            in   clock, all logic on posedge
//   rstn           in   asynchronous active-low reset
//   i_fifo_empty   in   FIFO empty flag
//   i_fifo_rddata  in   FIFO show-ahead read data (valid while !empty)
//   o_fifo_rden    out  FIFO pop strobe
//   o_valid        out  stream data valid
//   o_data         out  stream data (head entry)
//   o_last         out  last beat of the current burst
//   i_ready        in   downstream accept
//   i_flush        in   synchronous flush of buffer and burst counter
//   o_beat_cnt     out  index of the head beat within the burst
//   o_busy         out  buffer holds at least one word
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 16,
  localparam int CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_rddata,
  output logic              o_fifo_rden,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  input  logic              i_ready,
  input  logic              i_flush,
  output logic [CNT_W-1:0]  o_beat_cnt,
  output logic              o_busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Burst beat index advance with wrap at the last beat of the burst.
  function automatic logic [CNT_W-1:0] beat_next(input logic [CNT_W-1:0] beat);
    if (beat == LAST_BEAT) begin
      beat_next = '0;
    end else begin
      beat_next = beat + CNT_W'(1);
    end
  endfunction

  logic [1:0]        occ_q,  occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  beat_q, beat_d;

  logic pop_s;
  logic valid_s;
  logic fire_s;

  // The pop depends only on registered occupancy, FIFO status and flush.
  // rstn gates it so that no pop strobe is seen while reset is asserted.
  assign pop_s   = rstn & ~i_fifo_empty & ~i_flush & (occ_q < OCC_FULL);
  assign valid_s = (occ_q != OCC_EMPTY) & ~i_flush;
  assign fire_s  = valid_s & i_ready;

  assign o_fifo_rden = pop_s;
  assign o_valid     = valid_s;
  assign o_data      = head_q;
  assign o_last      = valid_s & (beat_q == LAST_BEAT);
  assign o_beat_cnt  = beat_q;
  assign o_busy      = (occ_q != OCC_EMPTY);

  // Next-state for occupancy, head/skid entries and burst beat counter.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    beat_d = beat_q;

    if (i_flush) begin
      // Flush wins over pop and fire. Buffered words are dropped; the FIFO is untouched.
      occ_d  = OCC_EMPTY;
      beat_d = '0;
    end else begin
      if (fire_s) begin
        beat_d = beat_next(beat_q);
      end else begin
        beat_d = beat_q;
      end

      case (occ_q)
        OCC_EMPTY: begin
          if (pop_s) begin
            head_d = i_fifo_rddata;
            occ_d  = OCC_ONE;
          end else begin
            occ_d  = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (pop_s && fire_s) begin
            // The head leaves and the popped word replaces it in the same cycle.
            head_d = i_fifo_rddata;
            occ_d  = OCC_ONE;
          end else if (pop_s) begin
            skid_d = i_fifo_rddata;
            occ_d  = OCC_FULL;
          end else if (fire_s) begin
            // head keeps stale data; it is not observable while o_valid=0.
            occ_d  = OCC_EMPTY;
          end else begin
            occ_d  = OCC_ONE;
          end
        end
        OCC_FULL: begin
          // No pop is possible here; a fire promotes skid to head.
          if (fire_s) begin
            head_d = skid_q;
            occ_d  = OCC_ONE;
          end else begin
            occ_d  = OCC_FULL;
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      skid_q <= '0;
      beat_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//   Directed bench for fifo_rd_stream. A behavioural show-ahead FIFO feeds the
//   DUT. Each test pushes its hand-computed expected beats ({last, data}) into a
//   scoreboard queue. A negedge monitor pops that queue on every accepted beat.
//   It also tracks a small occupancy/beat model to check o_valid, o_fifo_rden,
//   o_busy, o_beat_cnt and o_last each cycle.
//   Inputs change 1 ns after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  localparam int DATA_W = 128;
  localparam int BL     = 16;

  logic              clk;
  logic              rstn;
  logic              i_fifo_empty;
  logic [DATA_W-1:0] i_fifo_rddata;
  logic              o_fifo_rden;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_last;
  logic              i_ready;
  logic              i_flush;
  logic [3:0]        o_beat_cnt;
  logic              o_busy;

  fifo_rd_stream #(.DATA_W(DATA_W), .BURST_LEN(BL)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_fifo_empty  (i_fifo_empty),
    .i_fifo_rddata (i_fifo_rddata),
    .o_fifo_rden   (o_fifo_rden),
    .o_valid       (o_valid),
    .o_data        (o_data),
    .o_last        (o_last),
    .i_ready       (i_ready),
    .i_flush       (i_flush),
    .o_beat_cnt    (o_beat_cnt),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W-1:0] dummy_w;
  logic [DATA_W:0]   exp_e;

  logic pop_pend = 1'b0;
  int   occ_m    = 0;
  int   beat_m   = 0;
  int   fire_cnt = 0;
  int   pop_cnt  = 0;
  logic valid_e, rden_e, fire_e;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural show-ahead FIFO: pop decided at the previous negedge, then the outputs are refreshed.
  always begin
    @(posedge clk);
    #1;
    if (pop_pend && fifo_q.size() > 0) dummy_w = fifo_q.pop_front();
    #1;
    i_fifo_empty  = (fifo_q.size() == 0);
    i_fifo_rddata = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  end

  // Monitor: per-cycle model checks plus scoreboard compare on every accepted beat.
  always @(negedge clk) begin
    if (!rstn) begin
      occ_m    = 0;
      beat_m   = 0;
      pop_pend = 1'b0;
    end else begin
      valid_e = (occ_m != 0) && !i_flush;
      rden_e  = !i_fifo_empty && !i_flush && (occ_m < 2);
      fire_e  = valid_e && i_ready;
      check("o_valid",     {127'd0, o_valid},     {127'd0, valid_e});
      check("o_fifo_rden", {127'd0, o_fifo_rden}, {127'd0, rden_e});
      check("o_busy",      {127'd0, o_busy},      {127'd0, (occ_m != 0)});
      check("o_beat_cnt",  {124'd0, o_beat_cnt},  DATA_W'(beat_m));
      if (fire_e) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", o_data, 128'hDEAD_0000);
        end else begin
          exp_e = exp_q.pop_front();
          check("sb_data", o_data, exp_e[DATA_W-1:0]);
          check("sb_last", {127'd0, o_last}, {127'd0, exp_e[DATA_W]});
        end
        fire_cnt++;
      end
      if (rden_e) pop_cnt++;
      pop_pend = rden_e;
      if (i_flush) begin
        occ_m  = 0;
        beat_m = 0;
      end else begin
        occ_m = occ_m + (rden_e ? 1 : 0) - (fire_e ? 1 : 0);
        if (fire_e) beat_m = (beat_m == BL - 1) ? 0 : beat_m + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] w, input logic expect_it, input logic last);
    fifo_q.push_back(w);
    if (expect_it) exp_q.push_back({last, w});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn    = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    tick(2);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn          = 1'b0;
    i_ready       = 1'b0;
    i_flush       = 1'b0;
    i_fifo_empty  = 1'b1;
    i_fifo_rddata = '0;

    // 1: reset mid-stream drives outputs to zero without a clock edge
    do_reset();
    i_ready = 1'b1;
    push(128'h1, 1'b1, 1'b0);
    push(128'h2, 1'b1, 1'b0);
    push(128'h3, 1'b1, 1'b0);
    tick(2);
    check("t1_pre_beat", {124'd0, o_beat_cnt}, 128'd1);
    check("t1_pre_data", o_data, 128'h2);
    #2;
    rstn = 1'b0;
    #1;
    check("t1_rst_valid", {127'd0, o_valid},     128'd0);
    check("t1_rst_rden",  {127'd0, o_fifo_rden}, 128'd0);
    check("t1_rst_beat",  {124'd0, o_beat_cnt},  128'd0);
    check("t1_rst_data",  o_data,                128'd0);
    check("t1_rst_last",  {127'd0, o_last},      128'd0);
    check("t1_rst_busy",  {127'd0, o_busy},      128'd0);
    fifo_q.delete();
    exp_q.delete();
    tick(2);
    rstn = 1'b1;

    // 2: 32 words streamed back to back, o_last on 0x10 and 0x20
    do_reset();
    i_ready = 1'b1;
    for (int i = 1; i <= 32; i++) push(DATA_W'(i), 1'b1, (i % 16) == 0);
    fire_cnt = 0;
    pop_cnt  = 0;
    tick(33);
    check("t2_fires", DATA_W'(fire_cnt), 128'd32);
    check("t2_pops",  DATA_W'(pop_cnt),  128'd32);
    check("t2_sb_empty", DATA_W'(exp_q.size()), 128'd0);

    // 3: backpressure holds 0xA with exactly two pops, then drains in three clocks
    do_reset();
    pop_cnt = 0;
    push(128'hA, 1'b1, 1'b0);
    push(128'hB, 1'b1, 1'b0);
    push(128'hC, 1'b1, 1'b0);
    tick(6);
    check("t3_pops", DATA_W'(pop_cnt), 128'd2);
    check("t3_hold_data", o_data, 128'hA);
    check("t3_busy",  {127'd0, o_busy},      128'd1);
    check("t3_rden",  {127'd0, o_fifo_rden}, 128'd0);
    i_ready  = 1'b1;
    fire_cnt = 0;
    tick(3);
    check("t3_fires", DATA_W'(fire_cnt), 128'd3);
    check("t3_sb_empty", DATA_W'(exp_q.size()), 128'd0);

    // 4: toggling ready over 40 words
    do_reset();
    pop_cnt = 0;
    for (int i = 0; i < 40; i++) push(DATA_W'(256 + i), 1'b1, (i % 16) == 15);
    for (int c = 0; c < 100; c++) begin
      i_ready = ~i_ready;
      tick(1);
    end
    check("t4_pops", DATA_W'(pop_cnt), 128'd40);
    check("t4_sb_empty", DATA_W'(exp_q.size()), 128'd0);

    // 5: flush with occ=2 and beat_cnt=3, next word starts at beat 0
    do_reset();
    i_ready = 1'b1;
    push(128'h1, 1'b1, 1'b0);
    push(128'h2, 1'b1, 1'b0);
    push(128'h3, 1'b1, 1'b0);
    tick(5);
    check("t5_beat3", {124'd0, o_beat_cnt}, 128'd3);
    i_ready = 1'b0;
    push(128'h5, 1'b0, 1'b0);
    push(128'h6, 1'b0, 1'b0);
    tick(3);
    check("t5_pre_data", o_data, 128'h5);
    check("t5_pre_busy", {127'd0, o_busy}, 128'd1);
    i_flush = 1'b1;
    #1;
    check("t5_fl_valid", {127'd0, o_valid},     128'd0);
    check("t5_fl_rden",  {127'd0, o_fifo_rden}, 128'd0);
    check("t5_fl_busy",  {127'd0, o_busy},      128'd1);
    tick(1);
    i_flush = 1'b0;
    push(128'h7, 1'b1, 1'b0);
    i_ready = 1'b1;
    #1;
    check("t5_post_valid", {127'd0, o_valid},    128'd0);
    check("t5_post_beat",  {124'd0, o_beat_cnt}, 128'd0);
    check("t5_post_busy",  {127'd0, o_busy},     128'd0);
    tick(1);
    check("t5_w7_valid", {127'd0, o_valid},    128'd1);
    check("t5_w7_data",  o_data,               128'h7);
    check("t5_w7_beat",  {124'd0, o_beat_cnt}, 128'd0);
    tick(2);
    check("t5_sb_empty", DATA_W'(exp_q.size()), 128'd0);

    // 6: one word every third clock, each shown exactly once, one cycle after its pop
    do_reset();
    i_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push(DATA_W'(96 + k), 1'b1, 1'b0);
      tick(1);
      check("t6_valid", {127'd0, o_valid}, 128'd1);
      check("t6_data",  o_data, DATA_W'(96 + k));
      tick(1);
      check("t6_gap",   {127'd0, o_valid}, 128'd0);
      tick(1);
    end
    check("t6_sb_empty", DATA_W'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
